// File: rtl/gonso_pkg.sv
// Shared definitions for the gonso Wishbone register bank.
// Holds the register offsets inside the 4 KiB window, the channel FSM
// state encoding, the CTRL bit positions and the byte-lane merge helper.
package gonso_pkg;

  localparam logic [11:0] CTRL_OFF   = 12'h000;
  localparam logic [11:0] STATUS_OFF = 12'h004;
  localparam logic [11:0] START_OFF  = 12'h008;
  localparam logic [11:0] IN_BASE    = 12'h010;
  localparam logic [11:0] OUT_BASE   = 12'h014;
  localparam logic [11:0] CH_STRIDE  = 12'h008;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ch_state_e;

  // Replace the bytes of old_val selected by sel with those of new_val.
  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[b*8 +: 8] = new_val[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gonso_ch_fsm.sv
// Per-channel start/busy/done sequencer.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        START bit for this channel written this cycle
//   en           CTRL.en; a start is only taken when set
//   req_ready    core accepts the pending request
//   resp_valid   core result strobe (only honoured while waiting)
//   done_clr     write-1-to-clear of this channel's done bit
//   req_valid    request to the core, held until accepted
//   busy         channel is not idle
//   done         sticky completion flag
//   capture      result-load strobe for the OUT register
module gonso_ch_fsm
  import gonso_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  input  logic req_ready,
  input  logic resp_valid,
  input  logic done_clr,
  output logic req_valid,
  output logic busy,
  output logic done,
  output logic capture
);

  ch_state_e state_r;
  logic      req_valid_r;
  logic      done_r;

  assign capture   = (state_r == WAIT) & resp_valid;
  assign busy      = (state_r != IDLE);
  assign req_valid = req_valid_r;
  assign done      = done_r;

  // Channel state, request flag and sticky done; a completion beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && en) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end
        end
        REQ: begin
          if (req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
      if (capture) begin
        done_r <= 1'b1;
      end else if (done_clr) begin
        done_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gonso_wb_regbank.sv
// Wishbone slave register bank with NUM_CH operand/result channels.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone control, byte enables
//   wbs_adr_i/dat_i             byte address and write data
//   wbs_dat_o/ack_o             registered read data and acknowledge
//   req_valid/req_ready         per-channel request handshake to the cores
//   req_data                    operands, channel c at [c*IN_W +: IN_W]
//   resp_valid/resp_data        result strobes and results, channel c at [c*OUT_W +: OUT_W]
//   irq                         CTRL.irq_en & |done, registered
module gonso_wb_regbank
  import gonso_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3003_0000,
  parameter int          NUM_CH    = 4,
  parameter int          IN_W      = 20,
  parameter int          OUT_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic [31:0]             wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH*IN_W-1:0]  req_data,
  input  logic [NUM_CH-1:0]       resp_valid,
  input  logic [NUM_CH*OUT_W-1:0] resp_data,
  output logic                    irq
);

  logic              ack_r;
  logic [31:0]       dat_r;
  logic              irq_r;
  logic [1:0]        ctrl_r;
  logic [IN_W-1:0]   in_r      [NUM_CH];
  logic [OUT_W-1:0]  out_r     [NUM_CH];
  logic [IN_W-1:0]   in_next_s [NUM_CH];

  logic [NUM_CH-1:0] start_s, done_clr_s, busy_s, done_s, capture_s;
  logic [NUM_CH-1:0] in_hit_s, out_hit_s;
  logic              req_s, in_win_s, wr_s, rd_s;
  logic [11:0]       off_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  // The ack term keeps a request held across its ack from being serviced twice.
  assign req_s    = wbs_cyc_i & wbs_stb_i & ~ack_r;
  assign in_win_s = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign off_s    = {wbs_adr_i[11:2], 2'b00};
  assign wr_s     = req_s & wbs_we_i & in_win_s;
  assign rd_s     = req_s & ~wbs_we_i & in_win_s;
  assign unused_s = ^wbs_adr_i[1:0];

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq       = irq_r;

  // Channel address hits, START/W1C pulses and byte-merged operand values.
  always_comb begin
    start_s    = '0;
    done_clr_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_hit_s[c]  = (off_s == IN_BASE  + CH_STRIDE * 12'(c));
      out_hit_s[c] = (off_s == OUT_BASE + CH_STRIDE * 12'(c));
      in_next_s[c] = IN_W'(sel_merge(32'(in_r[c]), wbs_dat_i, wbs_sel_i));
    end
    if (wr_s && wbs_sel_i[0] && (off_s == START_OFF)) begin
      start_s = wbs_dat_i[NUM_CH-1:0];
    end else begin
      start_s = '0;
    end
    if (wr_s && wbs_sel_i[0] && (off_s == STATUS_OFF)) begin
      done_clr_s = wbs_dat_i[NUM_CH-1:0];
    end else begin
      done_clr_s = '0;
    end
  end

  // Read mux over the current register values; unmapped offsets read zero.
  always_comb begin
    rdata_s = 32'h0;
    case (off_s)
      CTRL_OFF:   rdata_s = {30'h0, ctrl_r};
      STATUS_OFF: rdata_s = {16'h0, 8'(busy_s), 8'(done_s)};
      START_OFF:  rdata_s = 32'h0;
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          rdata_s = rdata_s | ({32{in_hit_s[c]}}  & 32'(in_r[c]))
                            | ({32{out_hit_s[c]}} & 32'(out_r[c]));
        end
      end
    endcase
  end

  // Operand bus is a straight view of the IN registers.
  always_comb begin
    req_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_data[c*IN_W +: IN_W] = in_r[c];
    end
  end

  // Bus response, CTRL register and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r  <= 1'b0;
      dat_r  <= 32'h0;
      ctrl_r <= 2'b00;
      irq_r  <= 1'b0;
    end else begin
      ack_r <= req_s;
      if (rd_s) begin
        dat_r <= rdata_s;
      end else if (req_s) begin
        dat_r <= 32'h0;
      end
      if (wr_s && wbs_sel_i[0] && (off_s == CTRL_OFF)) begin
        ctrl_r <= wbs_dat_i[1:0];
      end
      irq_r <= ctrl_r[CTRL_IRQ_EN] & (|done_s);
    end
  end

  // IN registers freeze while their channel is busy; OUT loads on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        in_r[c]  <= '0;
        out_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_s && in_hit_s[c] && !busy_s[c]) begin
          in_r[c] <= in_next_s[c];
        end
        if (capture_s[c]) begin
          out_r[c] <= resp_data[c*OUT_W +: OUT_W];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gonso_ch_fsm u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[c]),
      .en         (ctrl_r[CTRL_EN]),
      .req_ready  (req_ready[c]),
      .resp_valid (resp_valid[c]),
      .done_clr   (done_clr_s[c]),
      .req_valid  (req_valid[c]),
      .busy       (busy_s[c]),
      .done       (done_s[c]),
      .capture    (capture_s[c])
    );
  end

endmodule

// File: tb/tb_gonso_wb_regbank.sv
// Directed bench for gonso_wb_regbank (4 channels, 20-bit operands/results).
module tb_gonso_wb_regbank;

  localparam logic [31:0] BASE = 32'h3003_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] adr   = 32'h0;
  logic [31:0] wdat  = 32'h0;
  logic [31:0] rdat;
  logic        ack;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready  = 4'h0;
  logic [79:0] req_data;
  logic [3:0]  resp_valid = 4'h0;
  logic [79:0] resp_data  = 80'h0;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gonso_wb_regbank #(
    .BASE_ADDR (BASE),
    .NUM_CH    (4),
    .IN_W      (20),
    .OUT_W     (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_dat_o  (rdat),
    .wbs_ack_o  (ack),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transfer; rv is pulsed on resp_valid during the request cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] rv,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; resp_valid = rv;
    lat = 0;
    rd  = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      resp_valid = 4'h0;
      if (ack === 1'b1) begin
        lat = i;
        rd  = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL wb_timeout: observed no ack at 0x%08h expected ack within 8 cycles", a);
    end
  endtask

  task automatic wb_wr(input logic [11:0] off, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'(off), d, 4'hF, 4'h0, rd, lat);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, 4'h0, rd, lat);
    check(tag, rd, exp);
  endtask

  task automatic pulse_ready(input logic [3:0] m);
    @(negedge clk); req_ready = m;
    @(negedge clk); req_ready = 4'h0;
  endtask

  task automatic pulse_resp(input logic [3:0] m);
    @(negedge clk); resp_valid = m;
    @(negedge clk); resp_valid = 4'h0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int n_acks;
    logic [11:0] offs [11];
    offs = '{12'h000, 12'h004, 12'h008, 12'h010, 12'h014, 12'h018,
             12'h01C, 12'h020, 12'h024, 12'h028, 12'h02C};

    // 1: reset state, mapped reads, unmapped and out-of-window writes
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_req_valid", 32'(req_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) rd_chk($sformatf("rst_read_%03h", offs[i]), offs[i], 32'h0);
    wb_xfer(1'b1, BASE + 32'h00C, 32'h123, 4'hF, 4'h0, rd, lat);
    check("unmapped_ack_lat", 32'(lat), 32'h1);
    rd_chk("unmapped_read", 12'h00C, 32'h0);
    wb_xfer(1'b1, BASE + 32'h1010, 32'h123, 4'hF, 4'h0, rd, lat);
    rd_chk("outwin_in0", 12'h010, 32'h0);

    // 2: one operation on channel 1
    wb_wr(12'h000, 32'h1);
    wb_wr(12'h018, 32'hABCDE);
    wb_wr(12'h008, 32'h2);
    check("t2_req_valid", 32'(req_valid), 32'h2);
    check("t2_req_data1", 32'(req_data[39:20]), 32'hABCDE);
    rd_chk("t2_status_busy", 12'h004, 32'h200);
    repeat (2) @(negedge clk);
    check("t2_req_held", 32'(req_valid), 32'h2);
    pulse_ready(4'h2);
    check("t2_req_dropped", 32'(req_valid), 32'h0);
    rd_chk("t2_status_wait", 12'h004, 32'h200);
    resp_data = {20'hFFFFF, 20'hFFFFF, 20'h00042, 20'hFFFFF};
    pulse_resp(4'h2);
    rd_chk("t2_out1", 12'h01C, 32'h42);
    rd_chk("t2_status_done", 12'h004, 32'h2);

    // 3: start ignored when disabled; operand writes dropped while busy
    wb_wr(12'h004, 32'h2);
    rd_chk("t3_status_clr", 12'h004, 32'h0);
    wb_wr(12'h000, 32'h0);
    wb_wr(12'h008, 32'hF);
    check("t3_no_req", 32'(req_valid), 32'h0);
    rd_chk("t3_status_idle", 12'h004, 32'h0);
    wb_wr(12'h000, 32'h1);
    wb_wr(12'h008, 32'hF);
    check("t3_req_all", 32'(req_valid), 32'hF);
    wb_wr(12'h010, 32'h5);
    rd_chk("t3_in0_kept", 12'h010, 32'h0);
    rd_chk("t3_status_busy", 12'h004, 32'hF00);
    pulse_ready(4'hF);
    check("t3_req_none", 32'(req_valid), 32'h0);
    resp_data = {20'h33333, 20'h0, 20'h11111, 20'h22222};
    pulse_resp(4'hB);
    rd_chk("t3_status_part", 12'h004, 32'h40B);
    wb_wr(12'h004, 32'hB);
    rd_chk("t3_status_ch2", 12'h004, 32'h400);

    // 4: interrupt, and done set racing its own clear
    wb_wr(12'h000, 32'h3);
    repeat (2) @(negedge clk);
    check("t4_irq_low", 32'(irq), 32'h0);
    resp_data = {20'h0, 20'h77777, 40'h0};
    pulse_resp(4'h4);
    repeat (2) @(negedge clk);
    check("t4_irq_high", 32'(irq), 32'h1);
    rd_chk("t4_out2", 12'h024, 32'h77777);
    rd_chk("t4_status_done2", 12'h004, 32'h4);
    wb_wr(12'h008, 32'h4);
    pulse_ready(4'h4);
    resp_data = {20'h0, 20'h12345, 40'h0};
    wb_xfer(1'b1, BASE + 32'h004, 32'h4, 4'hF, 4'h4, rd, lat);
    rd_chk("t4_set_wins", 12'h004, 32'h4);
    check("t4_irq_stays", 32'(irq), 32'h1);
    rd_chk("t4_out2_new", 12'h024, 32'h12345);
    wb_wr(12'h004, 32'h4);
    repeat (2) @(negedge clk);
    check("t4_irq_cleared", 32'(irq), 32'h0);
    rd_chk("t4_status_zero", 12'h004, 32'h0);

    // 5: byte enables, width masking, held strobe acked once
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h010; wdat = 32'hFFFF_FFFF; sel = 4'b0010;
    n_acks = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (ack === 1'b1) n_acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("t5_one_ack", 32'(n_acks), 32'h1);
    @(negedge clk);
    check("t5_ack_idle", 32'(ack), 32'h0);
    rd_chk("t5_in0_sel", 12'h010, 32'h0FF00);
    check("t5_req_data0", 32'(req_data[19:0]), 32'h0FF00);
    wb_wr(12'h010, 32'hFFFF_FFFF);
    rd_chk("t5_in0_width", 12'h010, 32'hFFFFF);

    // 6: reset while channel 0 waits for its result
    wb_wr(12'h008, 32'h1);
    pulse_ready(4'h1);
    rd_chk("t6_status_wait", 12'h004, 32'h100);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h004; sel = 4'hF;
    @(posedge clk);
    #1;
    check("t6_ack_before", 32'(ack), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", 32'(ack), 32'h0);
    check("t6_rst_req", 32'(req_valid), 32'h0);
    check("t6_rst_dat", rdat, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("t6_status", 12'h004, 32'h0);
    rd_chk("t6_ctrl", 12'h000, 32'h0);
    resp_data = {60'h0, 20'h99999};
    pulse_resp(4'h1);
    rd_chk("t6_out0_ignored", 12'h014, 32'h0);
    rd_chk("t6_status_after", 12'h004, 32'h0);
    check("t6_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
